// File: rtl/sram_burst_seq.sv
// rtl/sram_burst_seq.sv - splits burst commands into single-word sram_ctrl transactions
// Optional macro SRAM_BURST_SEQ_PACE_EN adds a pace_tick input that gates read issues.
module sram_burst_seq #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
`ifdef SRAM_BURST_SEQ_PACE_EN
  input  logic              pace_tick,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ctrl_start_n,
  output logic              ctrl_rw,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_data_write,
  input  logic              ctrl_ready,
  input  logic [DATA_W-1:0] ctrl_data_read
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RHOLD} state_t;

  state_t             state, state_d;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   remaining;
  logic               busy_q, done_q, busy_seen, rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               pace_ok, issue, wait_exit, advance, last;

`ifdef SRAM_BURST_SEQ_PACE_EN
  assign pace_ok = pace_tick;
`else
  assign pace_ok = 1'b1;
`endif

  assign last      = (remaining == '0);
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign ctrl_rw   = rw_q;
  assign ctrl_addr = addr_q;

  always_comb begin
    state_d         = state;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    ctrl_start_n    = 1'b1;
    ctrl_data_write = '0;
    issue           = 1'b0;
    wait_exit       = 1'b0;
    advance         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (!rw_q) ctrl_data_write = wr_data;
        if (ctrl_ready && (rw_q ? pace_ok : wr_valid)) begin
          issue        = 1'b1;
          ctrl_start_n = 1'b0;
          wr_ready     = !rw_q;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        // ready must be seen low first, or we could exit before sram_ctrl left idle
        if (ctrl_ready && busy_seen) begin
          wait_exit = 1'b1;
          if (rw_q) state_d = RHOLD;
          else      advance = 1'b1;
        end
      end
      RHOLD: begin
        if (rd_ready) advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (advance) state_d = last ? IDLE : ISSUE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rw_q       <= 1'b1;
      addr_q     <= '0;
      remaining  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_seen  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state  <= state_d;
      done_q <= 1'b0;
      if (state == IDLE && cmd_valid) begin
        rw_q      <= cmd_rw;
        addr_q    <= cmd_addr;
        remaining <= cmd_len;
        busy_q    <= 1'b1;
      end
      if (issue)
        busy_seen <= 1'b0;
      else if (state == WAIT && !ctrl_ready)
        busy_seen <= 1'b1;
      if (wait_exit && rw_q) begin
        rd_data_q  <= ctrl_data_read;
        rd_valid_q <= 1'b1;
      end
      if (advance) begin
        if (state == RHOLD) rd_valid_q <= 1'b0;
        addr_q <= addr_q + ADDR_W'(1);
        if (last) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          remaining <= remaining - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_burst_seq.sv
// tb/tb_sram_burst_seq.sv - directed burst vectors against a small sram_ctrl model
`timescale 1ns/1ps
module tb_sram_burst_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [17:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_ready = 1'b1;
  logic        cmd_ready, wr_ready, rd_valid, busy, done;
  logic [15:0] rd_data, ctrl_data_write, ctrl_data_read;
  logic        ctrl_start_n, ctrl_rw, ctrl_ready;
  logic [17:0] ctrl_addr;
`ifdef SRAM_BURST_SEQ_PACE_EN
  logic        pace_tick = 1'b1;
  logic        pace_mode = 1'b0;
`endif

  sram_burst_seq dut (
`ifdef SRAM_BURST_SEQ_PACE_EN
    .pace_tick(pace_tick),
`endif
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ctrl_start_n(ctrl_start_n), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
    .ctrl_data_write(ctrl_data_write), .ctrl_ready(ctrl_ready),
    .ctrl_data_read(ctrl_data_read)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sram_ctrl model: ready drops for m_lat cycles after a start, read data valid when it returns
  logic [15:0] mem [0:1023] = '{default: 16'h0};
  int          m_busy = 0;
  int          m_lat = 1;
  logic [9:0]  m_addr = '0;
  logic        m_rw = 1'b0;
  logic [15:0] m_rdata = '0;
  always @(posedge clk) begin
    if (m_busy > 0) begin
      if (m_busy == 1 && m_rw) m_rdata <= mem[m_addr];
      m_busy <= m_busy - 1;
    end else if (!ctrl_start_n) begin
      m_busy <= m_lat;
      m_addr <= ctrl_addr[9:0];
      m_rw   <= ctrl_rw;
      if (!ctrl_rw) mem[ctrl_addr[9:0]] <= ctrl_data_write;
    end
  end
  assign ctrl_ready     = (m_busy == 0);
  assign ctrl_data_read = m_rdata;

  // monitor
  int          st_cyc[$];
  logic [17:0] st_addr[$];
  logic [15:0] st_data[$];
  logic [15:0] rd_got[$];
  int done_cnt = 0, rdv_cycles = 0, rd_hs_cnt = 0, wr_take_cnt = 0;
  int err_nowr = 0, err_busy = 0, err_wrready_rd = 0, err_unstable = 0, err_busy_done = 0, err_pace = 0;
  logic        prev_rdv = 1'b0, prev_rdr = 1'b0;
  logic [15:0] prev_rdd = '0;
  always @(negedge clk) begin
    if (!ctrl_start_n) begin
      st_cyc.push_back(cyc);
      st_addr.push_back(ctrl_addr);
      st_data.push_back(ctrl_data_write);
      if (!ctrl_rw && !wr_valid) err_nowr++;
      if (!busy) err_busy++;
`ifdef SRAM_BURST_SEQ_PACE_EN
      if (ctrl_rw && !pace_tick) err_pace++;
`endif
    end
    if (wr_valid && wr_ready) wr_take_cnt++;
    if (wr_ready && ctrl_rw) err_wrready_rd++;
    if (rd_valid) begin
      rdv_cycles++;
      if (prev_rdv && !prev_rdr && rd_data != prev_rdd) err_unstable++;
    end
    if (rd_valid && rd_ready) begin
      rd_got.push_back(rd_data);
      rd_hs_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (busy) err_busy_done++;
    end
    prev_rdv = rd_valid;
    prev_rdr = rd_ready;
    prev_rdd = rd_data;
  end

  // stream driver, reconfigured per burst by burst_id
  int          burst_id = 0, drv_id = 0;
  logic [15:0] wr_base = '0;
  int          wr_take0 = 0, wr_gap = 0, rd_hs0 = 0, stall_word = -1, stall_cyc = 0;
  int          seen_take = 0, gap_left = 0, stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (burst_id != drv_id) begin
      drv_id     = burst_id;
      stall_left = stall_cyc;
      gap_left   = 0;
    end
    if (wr_take_cnt != seen_take) begin
      seen_take = wr_take_cnt;
      gap_left  = wr_gap;
    end
    wr_data = wr_base + 16'(wr_take_cnt - wr_take0);
    if (gap_left > 0) begin
      wr_valid = 1'b0;
      gap_left--;
    end else begin
      wr_valid = 1'b1;
    end
    if (rd_valid && (rd_hs_cnt - rd_hs0) == stall_word && stall_left > 0) begin
      rd_ready = 1'b0;
      stall_left--;
    end else begin
      rd_ready = 1'b1;
    end
`ifdef SRAM_BURST_SEQ_PACE_EN
    pace_tick = pace_mode ? (cyc % 10 == 0) : 1'b1;
`endif
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        rw;
    logic [17:0] addr;
    logic [7:0]  len;
    logic [15:0] base;
    int          gap;
    int          stall_word;
    int          stall_cyc;
    int          exp_starts;
    int          exp_spacing;
    logic [17:0] exp_last;
    int          exp_rdv;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int s0, r0, d0, rv0, t, n;
    s0 = st_cyc.size(); r0 = rd_got.size(); d0 = done_cnt; rv0 = rdv_cycles;
    wr_base = v.base; wr_take0 = wr_take_cnt; wr_gap = v.gap;
    rd_hs0 = rd_hs_cnt; stall_word = v.stall_word; stall_cyc = v.stall_cyc;
    burst_id++;
    t = 0;
    while (!cmd_ready && t < 100) begin tick(); t++; end
    cmd_rw = v.rw; cmd_addr = v.addr; cmd_len = v.len; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin tick(); t++; end
    check({tag, " done_timeout"}, 32'(t < 2000), 32'd1);
    repeat (3) tick();
    check({tag, " done_pulses"}, done_cnt - d0, 32'd1);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    n = st_cyc.size() - s0;
    check({tag, " starts"}, n, v.exp_starts);
    if (n > 0) check({tag, " last_addr"}, 32'(st_addr[s0+n-1]), 32'(v.exp_last));
    for (int j = 0; j < n && j < v.exp_starts; j++) begin
      check({tag, " addr"}, 32'(st_addr[s0+j]), 32'(18'(v.addr + 18'(j))));
      if (!v.rw) check({tag, " wdata"}, 32'(st_data[s0+j]), 32'(16'(v.base + 16'(j))));
      if (j > 0 && v.exp_spacing != 0)
        check({tag, " spacing"}, st_cyc[s0+j] - st_cyc[s0+j-1], v.exp_spacing);
    end
    if (v.rw) begin
      check({tag, " rd_words"}, rd_got.size() - r0, v.exp_starts);
      for (int j = 0; j < v.exp_starts && r0 + j < rd_got.size(); j++)
        check({tag, " rdata"}, 32'(rd_got[r0+j]), 32'(16'(v.base + 16'(j))));
    end
    check({tag, " rdv_cycles"}, rdv_cycles - rv0, v.exp_rdv);
  endtask

  initial begin
    vec_t vecs[8];
    int   s0, d0, r0, t, c;
    vecs[0] = '{1'b0, 18'h00010, 8'd3,   16'hA000, 0, -1, 0, 4,   3, 18'h00013, 0};
    vecs[1] = '{1'b1, 18'h00010, 8'd3,   16'hA000, 0, -1, 0, 4,   4, 18'h00013, 4};
    vecs[2] = '{1'b1, 18'h00010, 8'd3,   16'hA000, 0,  2, 5, 4,   0, 18'h00013, 9};
    vecs[3] = '{1'b0, 18'h3FFFE, 8'd2,   16'hB000, 4, -1, 0, 3,   5, 18'h00000, 0};
    vecs[4] = '{1'b1, 18'h3FFFE, 8'd2,   16'hB000, 0, -1, 0, 3,   4, 18'h00000, 3};
    vecs[5] = '{1'b0, 18'h00020, 8'd0,   16'hC000, 0, -1, 0, 1,   0, 18'h00020, 0};
    vecs[6] = '{1'b1, 18'h00020, 8'd0,   16'hC000, 0, -1, 0, 1,   0, 18'h00020, 1};
    vecs[7] = '{1'b0, 18'h00100, 8'd255, 16'hD000, 0, -1, 0, 256, 3, 18'h001FF, 0};

    repeat (3) tick();
    reset = 1'b0;
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst start_n", 32'(ctrl_start_n), 32'd1);
    check("rst ctrl_rw", 32'(ctrl_rw), 32'd1);
    check("rst ctrl_addr", 32'(ctrl_addr), 32'd0);
    check("rst ctrl_wdata", 32'(ctrl_data_write), 32'd0);
    check("rst wr_ready", 32'(wr_ready), 32'd0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // reset during WAIT of word 2 of a len=7 read, with sram_ctrl still busy afterwards
    m_lat = 6;
    burst_id++; stall_word = -1;
    s0 = st_cyc.size(); d0 = done_cnt;
    cmd_rw = 1'b1; cmd_addr = 18'h00010; cmd_len = 8'd7; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    t = 0;
    while (st_cyc.size() < s0 + 2 && t < 200) begin tick(); t++; end
    check("mrst second_start", 32'(t < 200), 32'd1);
    c = (st_cyc.size() >= s0 + 2) ? st_cyc[s0+1] : 0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst cmd_ready", 32'(cmd_ready), 32'd1);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst rd_valid", 32'(rd_valid), 32'd0);
    check("mrst done", 32'(done), 32'd0);
    r0 = rd_got.size();
    cmd_rw = 1'b1; cmd_addr = 18'h00011; cmd_len = 8'd0; cmd_valid = 1'b1;
    tick();
    check("mrst cmd_ready_busy", 32'(cmd_ready), 32'd0);
    repeat (2) tick();
    cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 200) begin tick(); t++; end
    repeat (10) tick();
    check("mrst done_pulses", done_cnt - d0, 32'd1);
    check("mrst starts", st_cyc.size() - s0, 32'd3);
    if (st_cyc.size() >= s0 + 3) check("mrst start_wait", st_cyc[s0+2] - c, 32'd7);
    check("mrst rd_words", rd_got.size() - r0, 32'd1);
    if (rd_got.size() > r0) check("mrst rdata", 32'(rd_got[r0]), 32'hA001);
    m_lat = 1;

`ifdef SRAM_BURST_SEQ_PACE_EN
    pace_mode = 1'b1;
    run_vec("pace_rd", '{1'b1, 18'h00010, 8'd1, 16'hA000, 0, -1, 0, 2, 0, 18'h00011, 2});
    run_vec("pace_wr", vecs[0]);
    pace_mode = 1'b0;
    check("pace_violations", err_pace, 32'd0);
`endif

    check("start_without_wr_valid", err_nowr, 32'd0);
    check("start_without_busy", err_busy, 32'd0);
    check("wr_ready_in_read", err_wrready_rd, 32'd0);
    check("rd_unstable", err_unstable, 32'd0);
    check("busy_with_done", err_busy_done, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_burst_seq.md
Name: sram_burst_seq

Overview:
- Request sequencer directly upstream of sram_ctrl.
- Accepts one burst command at a time: read or write, base address, word count.
- Breaks the burst into single-word start_n/rw transactions on sram_ctrl's native interface.
- Streams write data in and read data out through valid/ready handshakes.
- Replaces the hand-coded write1/write2/read1/read2 loops in top-level test designs.

Parameters:
- ADDR_W, 18, SRAM word address width; matches sram_ctrl addr_in.
- DATA_W, 16, SRAM data width; matches sram_ctrl data_write/data_read.
- LEN_W, 8, burst length field width; burst = cmd_len+1 words (1..2^LEN_W).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command
- cmd_rw  in  1  1=read, 0=write (same polarity as sram_ctrl rw)
- cmd_addr  in  ADDR_W  burst base word address
- cmd_len  in  LEN_W  burst length minus one
- wr_valid  in  1  write word available
- wr_ready  out  1  write word consumed this cycle
- wr_data  in  DATA_W  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  downstream takes read word
- rd_data  out  DATA_W  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse on burst completion
- ctrl_start_n  out  1  to sram_ctrl start_n, active-low
- ctrl_rw  out  1  to sram_ctrl rw
- ctrl_addr  out  ADDR_W  to sram_ctrl addr_in
- ctrl_data_write  out  DATA_W  to sram_ctrl data_write
- ctrl_ready  in  1  from sram_ctrl ready
- ctrl_data_read  in  DATA_W  from sram_ctrl data_read

Behaviour:
- Single clock; all registers reset synchronously on reset=1.
- Reset values: state=IDLE, busy=0, done=0, rd_valid=0, rd_data=0, ctrl_start_n=1, ctrl_rw=1, ctrl_addr=0, ctrl_data_write=0, wr_ready=0. cmd_ready=1 from the first cycle after reset.
- States: IDLE, ISSUE, WAIT, RHOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch rw, addr, remaining=cmd_len; busy<=1; go to ISSUE.
- ISSUE:
  - ctrl_start_n=0 (combinational) only when ctrl_ready=1 AND (rw=1 OR wr_valid=1).
  - Write: wr_ready=1 in that same cycle; ctrl_data_write=wr_data combinationally (sram_ctrl latches it on start).
  - On issue, go to WAIT and clear busy_seen. Otherwise hold in ISSUE.
  - ctrl_rw and ctrl_addr are driven from the latched rw and current address throughout ISSUE and WAIT.
- WAIT:
  - Set busy_seen when ctrl_ready=0.
  - Exit only on ctrl_ready=1 with busy_seen=1. Guards against sampling ready before sram_ctrl leaves its idle state.
  - Write exit: advance (below).
  - Read exit: rd_data<=ctrl_data_read, rd_valid<=1, go to RHOLD.
- RHOLD: hold rd_valid and rd_data stable until rd_ready=1; on the handshake, rd_valid<=0 and advance.
- Advance:
  - addr<=addr+1, wrapping modulo 2^ADDR_W (0x3FFFF -> 0x00000).
  - If remaining=0: done<=1 for one cycle, busy<=0, go to IDLE.
  - Else: remaining<=remaining-1, go to ISSUE.
- Throughput, no stalls: write = 1 word per 3 cycles; read = 1 word per 4 cycles when rd_ready is held high.
- cmd_valid outside IDLE is ignored (cmd_ready=0); no queuing.
- wr_valid outside ISSUE is ignored; wr_ready is never 1 during a read burst.
- Reset mid-burst:
  - Sequencer returns to IDLE immediately; the partial burst is abandoned with no done pulse.
  - A word already issued to sram_ctrl completes there independently.
  - The next ISSUE still waits for ctrl_ready=1.
- cmd_len=2^LEN_W-1 produces a burst of 2^LEN_W words; the remaining counter does not overflow.

Optional Feature:
- Macro: SRAM_BURST_SEQ_PACE_EN.
- Defined: adds input port pace_tick (1 bit, typically mod_m_count pulse). A read issue in ISSUE additionally requires pace_tick=1. Writes are unpaced.
- Not defined: no pace_tick port; read issue needs only ctrl_ready=1.

Test Plan:
- Write burst: cmd rw=0, addr=0x00010, len=3; wr_data 0xA000..0xA003 always valid -> 4 starts at addr 0x10..0x13, ctrl_data_write matches at each start, 3-cycle spacing, single done pulse, busy low the cycle after done.
- Read burst: rw=1, addr=0x00010, len=3; sram_ctrl model returns the stored words -> rd_data 0xA000..0xA003 in order; with rd_ready=1, rd_valid high for exactly 1 cycle per word.
- Backpressure: same read burst with rd_ready low for 5 cycles on word 2 -> rd_valid and rd_data stay stable, no extra ctrl_start_n, no word lost.
- Write starvation and wrap: rw=0, addr=0x3FFFE, len=2; wr_valid gaps of 4 cycles -> no start while wr_valid=0; addresses 0x3FFFE, 0x3FFFF, 0x00000.
- Mid-burst reset: reset for 1 cycle during WAIT of word 2 of a len=7 read -> next cycle state=IDLE, busy=0, rd_valid=0, no done pulse; a new len=0 command then completes normally.
- With SRAM_BURST_SEQ_PACE_EN: read len=1, pace_tick every 10 cycles -> each start coincides with pace_tick=1; a write burst is unaffected.
